// File: rtl/shared_reg_pkg.sv
// Purpose: shared types, limits and helper functions for the shared register arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shared_reg_pkg;

    // Largest requester count the arbiter is built for.
    localparam int MAX_N = 16;

    // Constant-evaluable ceil(log2(value)) used to size owner index and pointer.
    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Converts a one-hot vector to its bit position; zero input yields 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin pick of the first eligible requester at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any=0 means nobody is eligible this cycle.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = clog2_f(N)
) (
    input  logic [N-1:0]    elig,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [N-1:0]  rot;
    logic [N-1:0]  low;
    logic [IDXW:0] sum;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then map back to an absolute index.
    always_comb begin
        rot = N'({elig, elig} >> ptr);
        low = rot & (~rot + 1'b1);
        sum = {1'b0, ptr} + (IDXW+1)'(onehot_to_idx(MAX_N'(low)));
        if (sum >= (IDXW+1)'(N)) begin
            sum = sum - (IDXW+1)'(N);
        end
        idx = sum[IDXW-1:0];
        any = |elig;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Purpose: one W-bit register shared by N requesters, round-robin arbitrated, with sync clear.
// Latency: req seen at edge E -> gnt pulse and new q visible together just after E.
// Backpressure: losers keep req high and retry; last winner is masked one cycle.
// Optional: SHARED_REG_LOCK_EN adds a lock input letting the current owner rewrite every cycle.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int IDXW = clog2_f(N)
) (
    input  logic              clk,
    input  logic              r,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    din,
    input  logic              clr,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N-1:0]      lock,
`endif
    output logic [N-1:0]      gnt,
    output logic [W-1:0]      q,
    output logic [IDXW-1:0]   q_owner,
    output logic              q_vld
);

    logic [N-1:0]    gnt_q,     gnt_d;
    logic [W-1:0]    q_q,       q_d;
    logic [IDXW-1:0] q_owner_q, q_owner_d;
    logic            q_vld_q,   q_vld_d;
    logic [IDXW-1:0] ptr_q,     ptr_d;

    logic [N-1:0]    owner_oh;
    logic            lock_hold;
    logic [N-1:0]    elig;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic [W-1:0]    pick_dat;
    logic [IDXW:0]   ptr_inc;
    logic [IDXW-1:0] ptr_nxt;

    // Eligibility: normally mask last cycle's winner; a held lock restricts eligibility to the owner.
    always_comb begin
        owner_oh = N'(1) << q_owner_q;
`ifdef SHARED_REG_LOCK_EN
        lock_hold = q_vld_q & lock[q_owner_q];
`else
        lock_hold = 1'b0;
`endif
        if (lock_hold) begin
            elig = req & owner_oh;
        end else begin
            elig = req & ~gnt_q;
        end
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .elig (elig),
        .ptr  (ptr_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign pick_dat = din[int'(pick_idx)*W +: W];

    // Pointer moves to the slot just after the winner, wrapping N-1 -> 0.
    always_comb begin
        ptr_inc = {1'b0, pick_idx} + 1'b1;
        if (ptr_inc == (IDXW+1)'(N)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = ptr_inc[IDXW-1:0];
        end
    end

    // Next state: clear beats a grant; without clear or winner everything but gnt holds.
    always_comb begin
        gnt_d     = '0;
        q_d       = q_q;
        q_owner_d = q_owner_q;
        q_vld_d   = q_vld_q;
        ptr_d     = ptr_q;
        if (clr) begin
            q_d       = '0;
            q_owner_d = '0;
            q_vld_d   = 1'b0;
        end else if (pick_any) begin
            q_d       = pick_dat;
            q_owner_d = pick_idx;
            q_vld_d   = 1'b1;
            gnt_d     = N'(1) << pick_idx;
            if (!lock_hold) begin
                ptr_d = ptr_nxt;
            end
        end
    end

    // State registers; reset is asynchronous, release is sampled on clk.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            gnt_q     <= '0;
            q_q       <= '0;
            q_owner_q <= '0;
            q_vld_q   <= 1'b0;
            ptr_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_owner_q <= q_owner_d;
            q_vld_q   <= q_vld_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_owner = q_owner_q;
    assign q_vld   = q_vld_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Purpose: self-checking bench for shared_reg_arbiter (N=4, W=8) with a behavioural reference model.
// Latency: model output compared 1 time unit after each rising edge.
// Backpressure: requesters retry by keeping req high until granted.
module tb_shared_reg_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int IDXW = 2;
    localparam int OW   = N + W + IDXW + 1;

    logic             clk = 1'b0;
    logic             r;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic             clr;
`ifdef SHARED_REG_LOCK_EN
    logic [N-1:0]     lock;
`endif
    logic [N-1:0]     gnt;
    logic [W-1:0]     q;
    logic [IDXW-1:0]  q_owner;
    logic             q_vld;

    int vectors = 0;
    int fails   = 0;

    // Reference model state: last winner (-1 = none), pointer, stored value.
    int          m_gnt;
    int          m_ptr;
    int          m_owner;
    logic [W-1:0] m_q;
    logic        m_vld;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .r       (r),
        .req     (req),
        .din     (din),
        .clr     (clr),
`ifdef SHARED_REG_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_vld   (q_vld)
    );

    always #5 clk = ~clk;

    task automatic mdl_reset();
        m_gnt   = -1;
        m_ptr   = 0;
        m_owner = 0;
        m_q     = '0;
        m_vld   = 1'b0;
    endtask

    // One rising edge of the arbitration rules, evaluated from current inputs.
    task automatic mdl_edge();
        int pick;
        bit locked;
        pick   = -1;
        locked = 1'b0;
`ifdef SHARED_REG_LOCK_EN
        locked = m_vld && lock[m_owner];
`endif
        if (clr) begin
            m_q = '0; m_vld = 1'b0; m_owner = 0; m_gnt = -1;
        end else begin
            if (locked) begin
                if (req[m_owner]) pick = m_owner;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (m_ptr + i) % N;
                    if (pick < 0 && req[j] && j != m_gnt) pick = j;
                end
            end
            if (pick >= 0) begin
                m_q     = din[pick*W +: W];
                m_owner = pick;
                m_vld   = 1'b1;
                m_gnt   = pick;
                if (!locked) m_ptr = (pick + 1) % N;
            end else begin
                m_gnt = -1;
            end
        end
    endtask

    function automatic logic [OW-1:0] mdl_out();
        logic [N-1:0] g;
        g = (m_gnt < 0) ? '0 : (N'(1) << m_gnt);
        return {g, m_q, IDXW'(m_owner), m_vld};
    endfunction

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic do_reset();
        req = '0; clr = 1'b0; din = '0;
        r = 1'b0;
        mdl_reset();
        #1;
        r = 1'b1;
    endtask

    task automatic test_reset();
        r = 1'b0; req = '0; clr = 1'b0; din = '0;
`ifdef SHARED_REG_LOCK_EN
        lock = '0;
`endif
        mdl_reset();
        #1;
        vectors++;
        if ({gnt, q, q_owner, q_vld} !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", {gnt, q, q_owner, q_vld}, OW'(0));
        end
        @(negedge clk);
        r = 1'b1;
    endtask

    task automatic test_single();
        logic [N-1:0] exp_g [3];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0000; exp_g[2] = 4'b0001;
        do_reset();
        req = 4'b0001;
        din[0 +: W] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (gnt !== exp_g[k] || q !== 8'hA5 || q_vld !== 1'b1 || q_owner !== 2'd0) begin
                fails++;
                $display("FAIL single_req edge%0d: got gnt=%b q=%h vld=%b own=%0d required gnt=%b q=a5 vld=1 own=0",
                         k + 1, gnt, q, q_vld, q_owner, exp_g[k]);
            end
        end
        req = '0;
    endtask

    task automatic test_all_rotate();
        do_reset();
        for (int i = 0; i < N; i++) din[i*W +: W] = W'(i * 8'h11);
        req = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (gnt !== (N'(1) << (k % N)) || q !== W'((k % N) * 8'h11) || {gnt, q, q_owner, q_vld} !== mdl_out()) begin
                fails++;
                $display("FAIL rotate edge%0d: got gnt=%b q=%h required gnt=%b q=%h",
                         k + 1, gnt, q, N'(1) << (k % N), W'((k % N) * 8'h11));
            end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_g [3];
        exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
        do_reset();
        for (int i = 0; i < N; i++) din[i*W +: W] = W'(8'hC0 + i);
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) req = 4'b0011;
            vectors++;
            if (gnt !== exp_g[k] || {gnt, q, q_owner, q_vld} !== mdl_out()) begin
                fails++;
                $display("FAIL wrap step%0d: got gnt=%b required gnt=%b", k, gnt, exp_g[k]);
            end
        end
        req = '0;
    endtask

    task automatic test_clr();
        din[2*W +: W] = 8'h77;
        req = 4'b0100;
        clr = 1'b1;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || q !== 8'h00 || q_vld !== 1'b0 || q_owner !== 2'd0) begin
            fails++;
            $display("FAIL clr_wins: got gnt=%b q=%h vld=%b own=%0d required 0000/00/0/0", gnt, q, q_vld, q_owner);
        end
        clr = 1'b0;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || q !== 8'h77 || q_vld !== 1'b1 || q_owner !== 2'd2) begin
            fails++;
            $display("FAIL after_clr: got gnt=%b q=%h vld=%b own=%0d required 0100/77/1/2", gnt, q, q_vld, q_owner);
        end
        req = '0;
    endtask

    task automatic test_async_reset();
        din[0 +: W] = 8'h5A;
        req = 4'b0001;
        tick();
        vectors++;
        if (q !== 8'h5A || q_vld !== 1'b1) begin
            fails++;
            $display("FAIL async_setup: got q=%h vld=%b required q=5a vld=1", q, q_vld);
        end
        req = '0;
        #2;
        r = 1'b0;
        mdl_reset();
        #1;
        vectors++;
        if ({gnt, q, q_owner, q_vld} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h required %h", {gnt, q, q_owner, q_vld}, OW'(0));
        end
        @(negedge clk);
        r = 1'b1;
        for (int i = 0; i < N; i++) din[i*W +: W] = W'(8'h30 + i);
        req = '1;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || q !== 8'h30 || {gnt, q, q_owner, q_vld} !== mdl_out()) begin
            fails++;
            $display("FAIL restart_from_0: got gnt=%b q=%h required gnt=0001 q=30", gnt, q);
        end
        req = '0;
    endtask

`ifdef SHARED_REG_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = '0;
        din[0 +: W] = 8'h01;
        din[1*W +: W] = 8'h10;
        req = 4'b0010;
        tick();
        lock = 4'b0010;
        req  = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            din[1*W +: W] = W'(8'h20 + k);
            tick();
            vectors++;
            if (gnt !== 4'b0010 || q !== W'(8'h20 + k) || q_owner !== 2'd1) begin
                fails++;
                $display("FAIL lock_hold cyc%0d: got gnt=%b q=%h own=%0d required gnt=0010 q=%h own=1",
                         k, gnt, q, q_owner, W'(8'h20 + k));
            end
        end
        lock = '0;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || q !== 8'h01 || {gnt, q, q_owner, q_vld} !== mdl_out()) begin
            fails++;
            $display("FAIL lock_release: got gnt=%b q=%h required gnt=0001 q=01", gnt, q);
        end
        req = '0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
            clr = ($urandom_range(0, 7) == 0);
`ifdef SHARED_REG_LOCK_EN
            lock = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
`endif
            tick();
            vectors++;
            if ({gnt, q, q_owner, q_vld} !== mdl_out()) begin
                fails++;
                $display("FAIL random cyc%0d: got {gnt,q,own,vld}=%h required %h", k, {gnt, q, q_owner, q_vld}, mdl_out());
            end
        end
        req = '0; clr = 1'b0;
`ifdef SHARED_REG_LOCK_EN
        lock = '0;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rotate();
        test_wrap();
        test_clr();
        test_async_reset();
`ifdef SHARED_REG_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Shares one W-bit storage register, a bank of D flip-flops, between N requesters.
- Requesters are arbitrated round-robin. The winner's data is loaded into the register, and the winner is told with a one-cycle grant.
- A synchronous clear input empties the register in the same way a synchronous reset clears a D flip-flop.
- Sits between producer blocks and the single shared state register that downstream logic reads.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, width of the register and of each requester's data.
- IDXW, $clog2(N), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- r  input  1  reset, asynchronous, active-low.
- req  input  N  level request per requester; held until that requester's gnt bit is seen.
- din  input  N*W  requester data; slice i is din[i*W +: W].
- clr  input  1  synchronous clear of the stored value.
- gnt  output  N  registered one-hot grant pulse, one cycle long.
- q  output  W  stored register value.
- q_owner  output  IDXW  index of the requester that last wrote q.
- q_vld  output  1  q holds data written since the last clear or reset.

Behaviour:
- Reset (r=0, asynchronous):
  - gnt=0, q=0, q_owner=0, q_vld=0.
  - Round-robin pointer ptr=0.
  - Release from reset is synchronous to clk. The first arbitration happens at the first rising edge with r=1.
- Eligibility at each rising edge: elig = req & ~gnt. A requester granted in the previous cycle is masked, so a requester that drops req on seeing gnt is never granted twice. Each requester gets at most one grant every 2 cycles.
- Priority at each rising edge, highest first:
  1. clr=1: q<=0, q_vld<=0, q_owner<=0, gnt<=0, ptr unchanged. Pending requests are not lost; they compete on the next edge.
  2. elig!=0:
     - idx = first set bit of elig, scanning from ptr upward and wrapping N-1 -> 0.
     - q<=din[idx], q_owner<=idx, q_vld<=1, gnt<=onehot(idx).
     - ptr<=(idx+1) mod N, wrapping N-1 -> 0.
  3. Otherwise: gnt<=0; q, q_owner, q_vld and ptr hold.
- Latency: req seen high at edge E results in gnt and the new q visible together after E. Zero idle cycles between grants to different requesters.
- Boundary cases:
  - A single requester holding req continuously is granted every other cycle.
  - All N requesting: grants rotate ptr, ptr+1, ... with no starvation. Worst-case wait is N edges.
  - clr arriving together with requests: clr wins, no grant that cycle.
  - Reset asserted in mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
  - din of non-granted requesters is ignored.

Optional Feature:
- Macro SHARED_REG_LOCK_EN.
- Defined:
  - Adds input lock, width N.
  - If q_vld=1 and lock[q_owner]=1, only requester q_owner is eligible. The gnt mask is bypassed for it, so it may write every cycle. Other requesters wait.
  - ptr does not advance while the lock is held.
  - clr still has priority and drops ownership, because q_vld becomes 0.
- Undefined: the lock port is absent and arbitration is pure round-robin as described above.

Decomposition:
- Package shared_reg_pkg:
  - function clog2_f for IDXW.
  - function onehot_to_idx.
  - constant MAX_N=16.
- One sub-module, rr_pick: purely combinational rotate-and-priority-encode.
  - Inputs: elig[N], ptr[IDXW].
  - Outputs: idx[IDXW], any.
  - All registers stay in shared_reg_arbiter.

Test Plan (N=4, W=8):
- Reset, then req=0001, din0=0xA5 held -> after edge 1: gnt=0001, q=0xA5, q_vld=1, q_owner=0. Edge 2: gnt=0000 (masked). Edge 3: gnt=0001 again.
- req=1111, din=i*0x11, held for 8 edges, requests kept high -> gnt sequence 0001,0010,0100,1000,0001,...; q tracks 0x00,0x11,0x22,0x33. No requester is skipped.
- ptr=3 (after granting 2), req=0011 -> next grant 0001 (wrap past 3 to 0), then 0010.
- clr=1 with req=0100 -> gnt=0, q=0x00, q_vld=0. Next edge with clr=0: gnt=0100, q=din2.
- Reset asserted between edges while q=0x5A, q_vld=1 -> q=0, q_vld=0, gnt=0 immediately, before the next edge. After release, arbitration starts from requester 0.
- With SHARED_REG_LOCK_EN: owner 1 holds lock[1]=1, req=0011 -> requester 1 is granted every cycle and requester 0 is blocked. Drop lock -> the next grant goes to 0.
